// File: rtl/bcd_updown_ssd_pkg.sv
// Shared constants for the BCD up/down counter and its 7-segment driver.
// Segment patterns are {a,b,c,d,e,f,g,dp}, active low, dp always dark.
`timescale 1ns/1ps
package bcd_updown_ssd_pkg;

  localparam int BCD_W = 4;
  localparam int SSD_W = 8;

  localparam logic [SSD_W-1:0] SEG_0     = 8'h03;
  localparam logic [SSD_W-1:0] SEG_1     = 8'h9F;
  localparam logic [SSD_W-1:0] SEG_2     = 8'h25;
  localparam logic [SSD_W-1:0] SEG_3     = 8'h0D;
  localparam logic [SSD_W-1:0] SEG_4     = 8'h99;
  localparam logic [SSD_W-1:0] SEG_5     = 8'h49;
  localparam logic [SSD_W-1:0] SEG_6     = 8'h41;
  localparam logic [SSD_W-1:0] SEG_7     = 8'h1F;
  localparam logic [SSD_W-1:0] SEG_8     = 8'h01;
  localparam logic [SSD_W-1:0] SEG_9     = 8'h09;
  localparam logic [SSD_W-1:0] SEG_BLANK = 8'hFF;

  function automatic logic [SSD_W-1:0] seg_decode(
    input logic [BCD_W-1:0] d
  );
    logic [SSD_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_updown_ssd_digit.sv
// One BCD digit of the up/down counter.
// carry doubles as borrow; it feeds the step input of the next digit up.
`timescale 1ns/1ps
module bcd_digit
  import bcd_updown_ssd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             step,
  input  logic             up_dn,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  logic at_edge;

  assign at_edge = up_dn ? (digit == 4'd9)
                         : (digit == 4'd0);
  assign carry   = step && at_edge;

  // clr beats load beats step; load saturates non-BCD codes to 9
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= (load_val > 4'd9) ? 4'd9 : load_val;
    end else if (step) begin
      if (at_edge)
        digit <= up_dn ? 4'd0 : 4'd9;
      else if (up_dn)
        digit <= digit + 4'd1;
      else
        digit <= digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_ssd.sv
// N-digit BCD up/down counter with prescaler, preset and wrap flag,
// driving a scanned multi-digit 7-segment display.
`timescale 1ns/1ps
module bcd_updown_ssd
  import bcd_updown_ssd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 131072,
  parameter int LZB      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clr,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    wrap,
  output logic [SSD_W-1:0]        segs,
  output logic [DIGITS-1:0]       ssd_ctl
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]    presc;
  logic             tick;
  logic [DIGITS:0]  chain;
  logic [BCD_W-1:0] digs [DIGITS];
  logic [SW-1:0]    scan_cnt;
  logic [IW-1:0]    idx;
  logic [DIGITS-1:0] blank;
  logic             higher_nz;

  assign tick     = en && (presc == P_LAST);
  assign chain[0] = tick;

  // Prescaler: free-runs while enabled, restarts on clr/load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (clr || load)
      presc <= '0;
    else if (en)
      presc <= tick ? '0 : presc + PW'(1);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[g*BCD_W +: BCD_W]),
      .step     (chain[g]),
      .up_dn    (up_dn),
      .digit    (count[g*BCD_W +: BCD_W]),
      .carry    (chain[g+1])
    );
    assign digs[g] = count[g*BCD_W +: BCD_W];
  end

  // Wrap: carry out of the MSD on an unpreempted tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wrap <= 1'b0;
    else
      wrap <= tick && !clr && !load && chain[DIGITS];
  end

  // Scan timer and digit index, independent of count control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == S_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == I_LAST) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Leading-zero mask: digit i>0 dark when it and all above are 0
  always_comb begin
    blank     = '0;
    higher_nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      higher_nz = higher_nz | (digs[i] != '0);
      blank[i]  = (LZB != 0) && !higher_nz;
    end
  end

  // Segment and enable registers share one index: no ghosting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs    <= SEG_0;
      ssd_ctl <= ~DIGITS'(1);
    end else begin
      ssd_ctl <= ~(DIGITS'(1) << idx);
      segs    <= blank[idx] ? SEG_BLANK
                            : seg_decode(digs[idx]);
    end
  end

endmodule
